mem_port_arbiter: RTL

- Shares one single-port unified memory between the core's instruction-fetch port (F stage) and data-access port (M stage).
- Serialises requests through a small FSM. Data has priority over fetch, with a programmable anti-starvation limit.
- Holds each transaction until the memory signals ready. Aborts with an error if the memory does not answer in time.
- Sits between the core top level and the memory model; the core stalls on an outstanding request until its ack.

---
 rtl/mem_port_arbiter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between the fetch and data ports of the core.
// Data wins by default; a pending fetch wins after STARVE_LIMIT consecutive data grants.
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int MAX_WAIT     = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [2:0]  d_size,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [2:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        busy
);

    // state  | meaning
    // IDLE   | arbitrating; also the cycle in which a completed ack is presented
    // I_BUSY | fetch transaction on the memory bus
    // D_BUSY | data transaction on the memory bus
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_I_BUSY = 2'd1;
    localparam logic [1:0] S_D_BUSY = 2'd2;

    localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam int WW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_LIMIT);
    localparam logic [WW-1:0] WAIT_LAST  = WW'(MAX_WAIT - 1);
    localparam logic          STARVE_EN  = (STARVE_LIMIT != 0);

    logic [1:0]    state;
    logic [SW-1:0] streak;
    logic [WW-1:0] wait_cnt;
    logic          lat_we;
    logic [2:0]    lat_size;
    logic [31:0]   lat_addr;
    logic [31:0]   lat_wdata;
    logic          d_win;
    logic          i_win;
    logic          grant_d;
    logic          grant_i;

    // The arbitration winner is picked from the raw requests; a winner whose ack
    // is on the wire this cycle still holds its req, so it is simply not granted.
    always_comb begin
        d_win   = d_req && !(i_req && STARVE_EN && (streak == STREAK_MAX));
        i_win   = i_req && !d_win;
        grant_d = d_win && !d_ack;
        grant_i = i_win && !i_ack;
    end

    assign busy      = (state != S_IDLE);
    assign mem_req   = busy;
    assign mem_we    = lat_we;
    assign mem_size  = lat_size;
    assign mem_addr  = lat_addr;
    assign mem_wdata = lat_wdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            streak    <= '0;
            wait_cnt  <= '0;
            lat_we    <= 1'b0;
            lat_size  <= 3'b000;
            lat_addr  <= 32'h0;
            lat_wdata <= 32'h0;
            i_ack     <= 1'b0;
            d_ack     <= 1'b0;
            err       <= 1'b0;
            i_rdata   <= 32'h0;
            d_rdata   <= 32'h0;
        end else begin
            i_ack <= 1'b0;
            d_ack <= 1'b0;
            err   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (grant_d) begin
                        state     <= S_D_BUSY;
                        wait_cnt  <= '0;
                        lat_we    <= d_we;
                        lat_size  <= d_size;
                        lat_addr  <= d_addr;
                        lat_wdata <= d_wdata;
                        if (streak != STREAK_MAX) streak <= streak + 1'b1;
                    end else if (grant_i) begin
                        state     <= S_I_BUSY;
                        wait_cnt  <= '0;
                        lat_we    <= 1'b0;
                        lat_size  <= 3'b010;
                        lat_addr  <= i_addr;
                        lat_wdata <= 32'h0;
                        streak    <= '0;
                    end
                end
                S_I_BUSY, S_D_BUSY: begin
                    if (mem_ready) begin
                        state <= S_IDLE;
                        if (state == S_D_BUSY) begin
                            d_ack   <= 1'b1;
                            d_rdata <= lat_we ? 32'h0 : mem_rdata;
                        end else begin
                            i_ack   <= 1'b1;
                            i_rdata <= mem_rdata;
                        end
                    end else if (wait_cnt == WAIT_LAST) begin
                        state <= S_IDLE;
                        err   <= 1'b1;
                        if (state == S_D_BUSY) begin
                            d_ack   <= 1'b1;
                            d_rdata <= 32'h0;
                        end else begin
                            i_ack   <= 1'b1;
                            i_rdata <= 32'h0;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
